// File: rtl/dram_frame_copy.sv
// DRAM-to-DRAM frame copy: bursts a WIDTH x HEIGHT frame through a FIFO from source to destination.
// Optional build macro DRAM_FRAME_COPY_PERF_EN adds the FRAME_CYCLES busy-cycle counter.
module dram_frame_copy #(
    parameter int          WIDTH      = 1600,
    parameter int          HEIGHT     = 900,
    parameter int          BURST      = 64,
    parameter logic [31:0] SRC_BASE   = 32'h0,
    parameter logic [31:0] DST_BASE   = 32'h0100_0000,
    parameter int          SRC_STRIDE = WIDTH,
    parameter int          DST_STRIDE = WIDTH,
    parameter int          FIFO_DEPTH = 256
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    output logic        BUSY_O,
    output logic        DONE,
    output logic        ERR,
    output logic        kick,
    input  logic        busy,
    output logic [31:0] read_num,
    output logic [31:0] read_addr,
    input  logic [31:0] buf_dout,
    input  logic        buf_we,
    input  logic        wr_ready,
    output logic [35:0] data_in,
    output logic        data_we,
    output logic [39:0] ctrl_in,
    output logic        ctrl_we,
    output logic [31:0] FRAME_CYCLES
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {R_IDLE, R_SPACE, R_KICK, R_BUSY} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_CMD, W_DATA} w_state_t;

    r_state_t    r_state_reg;
    w_state_t    w_state_reg;
    logic [11:0] rx_reg, ry_reg, wx_reg, wy_reg;
    logic [7:0]  beat_reg;
    logic        kick_reg, ctrl_we_reg, done_reg, busy_o_reg, err_reg;
    logic [31:0] read_addr_reg, read_num_reg;
    logic [39:0] ctrl_in_reg;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [31:0]   rd_q;
    logic [31:0]   byp_data_reg;
    logic          byp_valid_reg;
    logic [AW-1:0] wptr_reg, rptr_reg, rd_addr_next;
    logic [CW-1:0] count_reg;

    function automatic logic [7:0] burst_len(input logic [11:0] x);
        logic [12:0] rem;
        rem = 13'(WIDTH) - {1'b0, x};
        if (rem >= 13'(BURST))
            return 8'(BURST);
        else
            return 8'(rem);
    endfunction

    logic [7:0]  r_len, w_len;
    logic        r_line_end, r_frame_last, w_line_end, w_frame_last, w_beat_last;
    logic [31:0] rd_addr_calc, wr_addr_calc;
    logic        start_acc, fifo_full, fifo_empty, push_ok, pop_ok, w_final;

    assign r_len        = burst_len(rx_reg);
    assign w_len        = burst_len(wx_reg);
    assign r_line_end   = ({1'b0, rx_reg} + 13'(r_len)) == 13'(WIDTH);
    assign w_line_end   = ({1'b0, wx_reg} + 13'(w_len)) == 13'(WIDTH);
    assign r_frame_last = r_line_end && (ry_reg == 12'(HEIGHT - 1));
    assign w_frame_last = w_line_end && (wy_reg == 12'(HEIGHT - 1));
    assign w_beat_last  = (beat_reg == (w_len - 8'd1));
    assign rd_addr_calc = SRC_BASE + (((32'(ry_reg) * 32'(SRC_STRIDE)) + 32'(rx_reg)) << 2);
    assign wr_addr_calc = DST_BASE + (((32'(wy_reg) * 32'(DST_STRIDE)) + 32'(wx_reg)) << 2);

    assign start_acc  = START && !busy_o_reg;
    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign data_we    = (w_state_reg == W_DATA) && wr_ready;
    assign push_ok    = buf_we && !fifo_full;
    assign pop_ok     = data_we && !fifo_empty;
    assign w_final    = data_we && w_beat_last && w_frame_last;
    assign rd_addr_next = pop_ok ? (rptr_reg + AW'(1)) : rptr_reg;

    // Storage array with registered read; the read address looks one pop ahead so the head is
    // always ready (first-word-fall-through), and a bypass covers a write to that same slot.
    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wptr_reg] <= buf_dout;
        rd_q <= mem[rd_addr_next];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            count_reg     <= '0;
            byp_valid_reg <= 1'b0;
            byp_data_reg  <= 32'h0;
        end else begin
            if (push_ok)
                wptr_reg <= wptr_reg + AW'(1);
            rptr_reg      <= rd_addr_next;
            count_reg     <= count_reg + CW'(push_ok) - CW'(pop_ok);
            byp_valid_reg <= push_ok && (wptr_reg == rd_addr_next);
            byp_data_reg  <= buf_dout;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy_o_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            if (start_acc)
                busy_o_reg <= 1'b1;
            else if (w_final)
                busy_o_reg <= 1'b0;
            if (start_acc)
                err_reg <= 1'b0;
            else if ((buf_we && fifo_full) || (data_we && fifo_empty))
                err_reg <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state_reg   <= R_IDLE;
            rx_reg        <= '0;
            ry_reg        <= '0;
            kick_reg      <= 1'b0;
            read_addr_reg <= 32'h0;
            read_num_reg  <= 32'h0;
        end else begin
            case (r_state_reg)
                R_IDLE: if (start_acc) begin
                    rx_reg      <= '0;
                    ry_reg      <= '0;
                    r_state_reg <= R_SPACE;
                end
                R_SPACE: if ((32'(FIFO_DEPTH) - 32'(count_reg)) >= 32'(r_len)) begin
                    read_addr_reg <= rd_addr_calc;
                    read_num_reg  <= 32'(r_len);
                    kick_reg      <= 1'b1;
                    r_state_reg   <= R_KICK;
                end
                R_KICK: if (busy) begin
                    kick_reg    <= 1'b0;
                    r_state_reg <= R_BUSY;
                end
                R_BUSY: if (!busy) begin
                    if (r_line_end) begin
                        rx_reg <= '0;
                        ry_reg <= ry_reg + 12'd1;
                    end else begin
                        rx_reg <= rx_reg + {4'b0, r_len};
                    end
                    r_state_reg <= r_frame_last ? R_IDLE : R_SPACE;
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            w_state_reg <= W_IDLE;
            wx_reg      <= '0;
            wy_reg      <= '0;
            beat_reg    <= '0;
            ctrl_we_reg <= 1'b0;
            ctrl_in_reg <= 40'h0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (w_state_reg)
                W_IDLE: if (start_acc) begin
                    wx_reg      <= '0;
                    wy_reg      <= '0;
                    w_state_reg <= W_WAIT;
                end
                W_WAIT: if (32'(count_reg) >= 32'(w_len)) begin
                    ctrl_in_reg <= {w_len, wr_addr_calc};
                    ctrl_we_reg <= 1'b1;
                    w_state_reg <= W_CMD;
                end
                W_CMD: if (wr_ready) begin
                    ctrl_we_reg <= 1'b0;
                    beat_reg    <= '0;
                    w_state_reg <= W_DATA;
                end
                W_DATA: if (wr_ready) begin
                    beat_reg <= beat_reg + 8'd1;
                    if (w_beat_last) begin
                        if (w_line_end) begin
                            wx_reg <= '0;
                            wy_reg <= wy_reg + 12'd1;
                        end else begin
                            wx_reg <= wx_reg + {4'b0, w_len};
                        end
                        if (w_frame_last) begin
                            done_reg    <= 1'b1;
                            w_state_reg <= W_IDLE;
                        end else begin
                            w_state_reg <= W_WAIT;
                        end
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

`ifdef DRAM_FRAME_COPY_PERF_EN
    logic [31:0] perf_cnt_reg, frame_cycles_reg;

    // Counts BUSY_O cycles; BUSY_O is already low in the DONE cycle, so the latch sees the final total.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            perf_cnt_reg     <= 32'h0;
            frame_cycles_reg <= 32'h0;
        end else begin
            if (start_acc)
                perf_cnt_reg <= 32'h0;
            else if (busy_o_reg && (perf_cnt_reg != 32'hFFFF_FFFF))
                perf_cnt_reg <= perf_cnt_reg + 32'd1;
            if (done_reg)
                frame_cycles_reg <= perf_cnt_reg;
        end
    end
    assign FRAME_CYCLES = frame_cycles_reg;
`else
    assign FRAME_CYCLES = 32'h0;
`endif

    assign BUSY_O    = busy_o_reg;
    assign DONE      = done_reg;
    assign ERR       = err_reg;
    assign kick      = kick_reg;
    assign read_addr = read_addr_reg;
    assign read_num  = read_num_reg;
    assign ctrl_we   = ctrl_we_reg;
    assign ctrl_in   = ctrl_in_reg;
    assign data_in   = {4'hf, fifo_empty ? 32'h0 : (byp_valid_reg ? byp_data_reg : rd_q)};

endmodule

// File: tb/tb_dram_frame_copy.sv
// Randomized bench for dram_frame_copy: bridge models plus a frame-level scoreboard checked every cycle.
`timescale 1ns/1ps
module tb_dram_frame_copy;
    localparam int          W  = 100;
    localparam int          H  = 2;
    localparam int          B  = 64;
    localparam int          SS = 100;
    localparam int          DS = 128;
    localparam int          FD = 64;
    localparam logic [31:0] SB = 32'h0;
    localparam logic [31:0] DB = 32'h0100_0000;

    logic        CLK = 1'b0;
    logic        RST_N, START, busy, buf_we, wr_ready;
    logic        BUSY_O, DONE, ERR, kick, data_we, ctrl_we;
    logic [31:0] read_num, read_addr, buf_dout, FRAME_CYCLES;
    logic [35:0] data_in;
    logic [39:0] ctrl_in;

    dram_frame_copy #(
        .WIDTH(W), .HEIGHT(H), .BURST(B), .SRC_BASE(SB), .DST_BASE(DB),
        .SRC_STRIDE(SS), .DST_STRIDE(DS), .FIFO_DEPTH(FD)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .BUSY_O(BUSY_O), .DONE(DONE), .ERR(ERR),
        .kick(kick), .busy(busy), .read_num(read_num), .read_addr(read_addr),
        .buf_dout(buf_dout), .buf_we(buf_we), .wr_ready(wr_ready), .data_in(data_in),
        .data_we(data_we), .ctrl_in(ctrl_in), .ctrl_we(ctrl_we), .FRAME_CYCLES(FRAME_CYCLES)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int kick_rises = 0;
    int beat_total = 0;
    int tcyc = 0;
    int rise_t = 0;
    int done_t = 0;
    int wr_pct = 100;
    bit stall = 1'b0;
    logic [31:0] seed = 32'h1234_5678;

    logic [63:0] exp_rd[$];
    logic [39:0] exp_cmd[$];
    logic [31:0] exp_dat[$];
    logic [63:0] rd_log[$];
    logic [39:0] cmd_log[$];
    bit model_busy = 1'b0;
    bit prev_final = 1'b0;
    bit kick_prev  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] src_word(input logic [31:0] a, input logic [31:0] s);
        return (a * 32'h9E37_79B1) ^ s ^ {a[15:0], a[31:16]};
    endfunction

    // The whole frame as the spec describes it: per line, bursts of min(B, W-x).
    task automatic load_model();
        int len;
        logic [31:0] sa, da;
        exp_rd.delete();
        exp_cmd.delete();
        exp_dat.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x += len) begin
                len = (W - x < B) ? (W - x) : B;
                sa  = SB + 32'((y * SS + x) * 4);
                da  = DB + 32'((y * DS + x) * 4);
                exp_rd.push_back({sa, 32'(len)});
                exp_cmd.push_back({8'(len), da});
                for (int i = 0; i < len; i++)
                    exp_dat.push_back(src_word(sa + 32'(i * 4), seed));
            end
        end
    endtask

    always @(negedge CLK) begin
        bit final_now;
        final_now = 1'b0;
        if (!RST_N) begin
            exp_rd.delete();
            exp_cmd.delete();
            exp_dat.delete();
            model_busy = 1'b0;
            prev_final = 1'b0;
            kick_prev  = 1'b0;
        end else begin
            chk("busy_o", 64'(BUSY_O), 64'(model_busy));
            chk("done", 64'(DONE), 64'(prev_final));
            chk("err", 64'(ERR), 64'd0);
            if (kick && !kick_prev) begin
                kick_rises++;
                rd_log.push_back({read_addr, read_num});
                if (exp_rd.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
                else chk("rd_req", {read_addr, read_num}, exp_rd.pop_front());
            end
            if (ctrl_we && wr_ready) begin
                cmd_log.push_back(ctrl_in);
                if (exp_cmd.size() == 0) chk("cmd_unexpected", 64'd1, 64'd0);
                else chk("wr_cmd", 64'(ctrl_in), 64'(exp_cmd.pop_front()));
            end
            if (data_we) begin
                beat_total++;
                chk("we_ready", 64'(wr_ready), 64'd1);
                chk("strb", 64'(data_in[35:32]), 64'hf);
                if (exp_dat.size() == 0) chk("data_unexpected", 64'd1, 64'd0);
                else begin
                    chk("wr_data", 64'(data_in[31:0]), 64'(exp_dat.pop_front()));
                    if (exp_dat.size() == 0) final_now = 1'b1;
                end
            end
            if (final_now)
                model_busy = 1'b0;
            else if (START && !model_busy) begin
                model_busy = 1'b1;
                seed = $urandom;
                load_model();
            end
            prev_final = final_now;
            kick_prev  = kick;
        end
    end

    // Read bridge: accepts a kick after a short random delay, returns beats with gaps, then drops busy.
    initial begin
        int st, wait_n;
        logic [31:0] rb_addr, rb_num, rb_cnt;
        st = 0; wait_n = 0; rb_addr = 0; rb_num = 0; rb_cnt = 0;
        busy = 1'b0; buf_we = 1'b0; buf_dout = 32'h0;
        forever begin
            @(posedge CLK); #1;
            if (!RST_N) begin
                st = 0; busy = 1'b0; buf_we = 1'b0;
            end else begin
                case (st)
                    0: begin
                        buf_we = 1'b0;
                        if (kick) begin
                            rb_addr = read_addr; rb_num = read_num; rb_cnt = 0;
                            wait_n = $urandom_range(0, 2); st = 1;
                        end
                    end
                    1: begin
                        if (wait_n == 0) begin busy = 1'b1; st = 2; end
                        else wait_n--;
                    end
                    default: begin
                        if (rb_cnt < rb_num) begin
                            buf_we = ($urandom_range(0, 3) != 0);
                            if (buf_we) begin
                                buf_dout = src_word(rb_addr + rb_cnt * 4, seed);
                                rb_cnt++;
                            end
                        end else begin
                            buf_we = 1'b0; busy = 1'b0; st = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        wr_ready = 1'b0;
        forever begin
            @(posedge CLK); #1;
            wr_ready = stall ? 1'b0 : ($urandom_range(0, 99) < wr_pct);
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
        tcyc++;
    endtask

    task automatic start_frame();
        START = 1'b1;
        tick();
        START = 1'b0;
        rise_t = tcyc;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_kick"}, 64'(kick), 64'd0);
        chk({tag, "_ctrl_we"}, 64'(ctrl_we), 64'd0);
        chk({tag, "_data_we"}, 64'(data_we), 64'd0);
        chk({tag, "_done"}, 64'(DONE), 64'd0);
        chk({tag, "_busy_o"}, 64'(BUSY_O), 64'd0);
        chk({tag, "_err"}, 64'(ERR), 64'd0);
        chk({tag, "_read_addr"}, 64'(read_addr), 64'd0);
        chk({tag, "_read_num"}, 64'(read_num), 64'd0);
        chk({tag, "_ctrl_in"}, 64'(ctrl_in), 64'd0);
        chk({tag, "_data_in"}, 64'(data_in), 64'h0000_000F_0000_0000);
        chk({tag, "_frame_cycles"}, 64'(FRAME_CYCLES), 64'd0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!DONE && n < budget) begin
            tick();
            n++;
        end
        if (!DONE) chk({tag, "_done_timeout"}, 64'd0, 64'd1);
        done_t = tcyc;
        tick();
`ifdef DRAM_FRAME_COPY_PERF_EN
        chk({tag, "_frame_cycles"}, 64'(FRAME_CYCLES), 64'(done_t - rise_t));
`else
        chk({tag, "_frame_cycles"}, 64'(FRAME_CYCLES), 64'd0);
`endif
        chk({tag, "_busy_after"}, 64'(BUSY_O), 64'd0);
        chk({tag, "_left_data"}, 64'(exp_dat.size()), 64'd0);
        $display("frame %s: done at cycle %0d, %0d busy cycles", tag, done_t, done_t - rise_t);
    endtask

    initial begin
        logic [63:0] lit_rd  [4];
        logic [39:0] lit_cmd [4];
        int k0, b0;
        lit_rd[0]  = {32'h0000_0000, 32'd64};
        lit_rd[1]  = {32'h0000_0100, 32'd36};
        lit_rd[2]  = {32'h0000_0190, 32'd64};
        lit_rd[3]  = {32'h0000_0290, 32'd36};
        lit_cmd[0] = {8'd64, 32'h0100_0000};
        lit_cmd[1] = {8'd36, 32'h0100_0100};
        lit_cmd[2] = {8'd64, 32'h0100_0200};
        lit_cmd[3] = {8'd36, 32'h0100_0300};

        RST_N = 1'b0;
        START = 1'b0;
        repeat (2) tick();
        check_reset_vals("rst0");
        RST_N = 1'b1;
        tick();

        // Frame 1: full-rate writes, pin request lists and first-kick latency.
        rd_log.delete();
        cmd_log.delete();
        b0 = beat_total;
        start_frame();
        chk("busy_cycle1", 64'(BUSY_O), 64'd1);
        chk("kick_cycle1", 64'(kick), 64'd0);
        tick();
        chk("kick_cycle2", 64'(kick), 64'd1);
        wait_done("f1", 5000);
        chk("f1_beats", 64'(beat_total - b0), 64'(W * H));
        chk("f1_rd_count", 64'(rd_log.size()), 64'd4);
        chk("f1_cmd_count", 64'(cmd_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("f1_rd_lit%0d", i), (i < rd_log.size()) ? rd_log[i] : 64'hFFFF_FFFF_FFFF_FFFF, lit_rd[i]);
            chk($sformatf("f1_cmd_lit%0d", i), (i < cmd_log.size()) ? 64'(cmd_log[i]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(lit_cmd[i]));
        end

        // Frame 2: 30% write backpressure, plus an ignored START mid-frame.
        wr_pct = 30;
        b0 = beat_total;
        start_frame();
        repeat (60) tick();
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_done("f2", 8000);
        chk("f2_beats", 64'(beat_total - b0), 64'(W * H));

        // Frame 3: write side stalled; the FIFO holds one burst, so only one kick goes out.
        wr_pct = 100;
        stall = 1'b1;
        k0 = kick_rises;
        start_frame();
        repeat (500) tick();
        chk("stall_kicks", 64'(kick_rises - k0), 64'd1);
        chk("stall_err", 64'(ERR), 64'd0);
        stall = 1'b0;
        wait_done("f3", 5000);

        // Frame 4: reset mid-frame.
        wr_pct = 70;
        start_frame();
        repeat (120) tick();
        chk("busy_pre_rst", 64'(BUSY_O), 64'd1);
        @(posedge CLK); #3;
        RST_N = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        repeat (3) tick();
        RST_N = 1'b1;
        tick();

        // Frame 5: a full frame after the abort.
        wr_pct = 50;
        b0 = beat_total;
        start_frame();
        wait_done("f5", 8000);
        chk("f5_beats", 64'(beat_total - b0), 64'(W * H));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dram_frame_copy.md
# dram_frame_copy

Parametrised DRAM-to-DRAM frame copy engine, the successor to the fixed 1600x900 copy block. It reads a WIDTH x HEIGHT frame of 32-bit pixels through the DRAM read port in bursts of up to BURST words and buffers them in an internal FIFO. It then writes the frame to a destination region through the DRAM write port. Supports widths that are not a multiple of BURST, independent source and destination line strides, write-side backpressure, and a DONE pulse. It sits between the DRAM read/write bridges and the top-level sequencer.

## Interface
- WIDTH, 1600: pixels (32-bit words) per line, 1..4095
- HEIGHT, 900: lines per frame, 1..4095
- BURST, 64: max words per DRAM request, 1..255
- SRC_BASE, 32'h0: source byte address
- DST_BASE, 32'h0100_0000: destination byte address
- SRC_STRIDE, WIDTH: source line pitch in words, >= WIDTH
- DST_STRIDE, WIDTH: destination line pitch in words, >= WIDTH
- FIFO_DEPTH, 256: FIFO words, power of 2, >= BURST

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset, asynchronous and active-low.
- START  in  1  begin frame copy; sampled only in idle.
- BUSY_O  out  1  high from accepted START until DONE.
- DONE  out  1  one-cycle pulse after the last write data beat.
- ERR  out  1  sticky FIFO overflow/underflow flag; cleared on START.
- kick  out  1  read request; held until busy is seen high.
- busy  in  1  read bridge busy.
- read_num  out  32  words in the current read request.
- read_addr  out  32  byte address of the current read request.
- buf_dout  in  32  read data.
- buf_we  in  1  read data valid.
- wr_ready  in  1  write bridge can accept ctrl/data this cycle.
- data_in  out  36  {strb[35:32]=4'hf, data[31:0]}.
- data_we  out  1  write data valid.
- ctrl_in  out  40  {len[39:32], byte addr[31:0]}.
- ctrl_we  out  1  write command valid.
- FRAME_CYCLES  out  32  cycle count of the last frame; present only under the macro.

## Operation
- Burst length at column x = min(BURST, WIDTH-x), 8 bits. The last burst of a line is partial when WIDTH % BURST != 0. Bursts never cross lines.
- Read address = SRC_BASE + ((ry*SRC_STRIDE + rx) << 2). Write address = DST_BASE + ((wy*DST_STRIDE + wx) << 2). Products are 32-bit.
- Read FSM states:
  - R_IDLE: on START go to R_SPACE, and set BUSY_O and clear ERR.
  - R_SPACE: wait until FIFO_DEPTH - fifo_count >= len. Then register read_addr and read_num, and go to R_KICK.
  - R_KICK: kick=1 until busy=1, then go to R_BUSY.
  - R_BUSY: on busy=0, advance rx/ry. Go to R_SPACE, or to R_IDLE after the last burst of the frame.
- All buf_we beats of a request arrive before busy falls. Only one read is outstanding at a time.
- Write FSM states:
  - W_IDLE: on START go to W_WAIT.
  - W_WAIT: when fifo_count >= len, register ctrl_in and go to W_CMD.
  - W_CMD: ctrl_we=1. It is accepted when wr_ready=1, then go to W_DATA.
  - W_DATA: data_we = wr_ready. The FIFO pops on each data_we cycle. After len beats, advance wx/wy. Go to W_WAIT, or after the last beat pulse DONE and go to W_IDLE.
- Read and write FSMs run concurrently. Writes of line n overlap reads of line n+1.
- buf_we while the FIFO is full drops the word and sets ERR. A pop while empty cannot occur and also sets ERR.
- START while BUSY_O=1 is ignored.
- Reset mid-frame aborts immediately, flushes the FIFO, and returns both FSMs to idle. No DONE is issued.

## Timing
- Reset values: kick, ctrl_we, data_we, DONE, BUSY_O, ERR = 0. read_addr, read_num, ctrl_in = 0. data_in[35:32]=4'hf, data_in[31:0]=0. FRAME_CYCLES=0.
- START in cycle 0 gives BUSY_O=1 in cycle 1. The first kick comes in cycle 2 (FIFO empty).
- FIFO is first-word-fall-through. data_in[31:0] is valid in the same cycle as data_we.
- ctrl_we precedes the first data_we of its burst by at least 1 cycle.
- DONE comes 1 cycle after the final data_we. BUSY_O drops in the same cycle as DONE.
- With wr_ready=1 and busy returning promptly, write throughput is len beats per len+2 cycles.

## Configuration
- DRAM_FRAME_COPY_PERF_EN defined: a 32-bit counter runs while BUSY_O=1. It saturates at 32'hFFFF_FFFF. It is latched into FRAME_CYCLES on DONE.
- DRAM_FRAME_COPY_PERF_EN undefined: no counter is built, and FRAME_CYCLES is tied to 32'h0.

## Test plan
- Partial burst: WIDTH=100, HEIGHT=2, BURST=64, SRC_BASE=0 gives read requests (0x000,64), (0x100,36), (0x190,64), (0x290,36). ctrl_in addresses are the same offsets plus DST_BASE. Data is copied word-exact, then DONE.
- Stride: WIDTH=8, HEIGHT=3, DST_STRIDE=16 gives write addresses DST_BASE+0x00, +0x40, +0x80, with len=8 each.
- Backpressure: random wr_ready at 30% gives no data_we while wr_ready=0, exact beat counts, and ERR=0.
- Small FIFO: FIFO_DEPTH=64, BURST=64, with write stalled 500 cycles. Only one kick is issued until the FIFO drains, and ERR stays 0.
- START during a frame is ignored. RST_N low mid-frame gives all outputs at reset values the same cycle. A new START then copies a full frame correctly.
- With PERF_EN, a WIDTH=64, HEIGHT=1 frame with 10-cycle busy gives FRAME_CYCLES = cycles from BUSY_O rise to DONE. Without PERF_EN, FRAME_CYCLES=0.
